// File: rtl/cuckoo_kv_engine_if.sv
// Request/response bundle between a ledger client and the cuckoo key/value engine.
interface cuckoo_kv_engine_if #(
    parameter int KEY_W     = 32,
    parameter int VAL_W     = 32,
    parameter int VAL_DEPTH = 32
);
    localparam int AW = $clog2(VAL_DEPTH);
    localparam int CW = $clog2(VAL_DEPTH + 1);

    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [KEY_W-1:0] req_key;
    logic [VAL_W-1:0] req_data;
    logic             resp_valid;
    logic [2:0]       resp_status;
    logic [VAL_W-1:0] resp_value;
    logic [AW-1:0]    resp_addr;
    logic [CW-1:0]    entry_count;

    modport master (
        output req_valid, req_op, req_key, req_data,
        input  req_ready, resp_valid, resp_status, resp_value, resp_addr, entry_count
    );

    modport slave (
        input  req_valid, req_op, req_key, req_data,
        output req_ready, resp_valid, resp_status, resp_value, resp_addr, entry_count
    );
endinterface

// File: rtl/cuckoo_kv_engine.sv
// Two-table cuckoo hash key/value store with bounded kick loop, one-entry stash and
// saturating-safe credit/debit; one request at a time through a multi-cycle FSM.
module cuckoo_kv_engine #(
    parameter int KEY_W     = 32,
    parameter int VAL_W     = 32,
    parameter int T1_DEPTH  = 11,
    parameter int T2_DEPTH  = 22,
    parameter int VAL_DEPTH = 32,
    parameter int MAX_KICKS = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    cuckoo_kv_engine_if.slave kv
);
    localparam int AW  = $clog2(VAL_DEPTH);
    localparam int CW  = $clog2(VAL_DEPTH + 1);
    localparam int H1W = $clog2(T1_DEPTH);
    localparam int H2W = $clog2(T2_DEPTH);
    localparam int KW  = $clog2(MAX_KICKS + 1);

    localparam logic [1:0] OP_SEARCH = 2'd0, OP_INSERT = 2'd1, OP_CREDIT = 2'd2, OP_DEBIT = 2'd3;
    localparam logic [2:0] ST_OK = 3'd0, ST_NOT_FOUND = 3'd1, ST_DUPLICATE = 3'd2,
                           ST_FULL = 3'd3, ST_OVERFLOW = 3'd4, ST_UNDERFLOW = 3'd5;

    typedef enum logic [2:0] {IDLE, LOOKUP, MATCH, VREAD, VWRITE, PLACE1, PLACE2, RESP} state_t;
    typedef struct packed {
        logic [KEY_W-1:0] key;
        logic [AW-1:0]    addr;
    } ent_t;

    function automatic logic [H1W-1:0] h1(input logic [KEY_W-1:0] k);
        return H1W'(k % KEY_W'(T1_DEPTH));
    endfunction

    function automatic logic [H2W-1:0] h2(input logic [KEY_W-1:0] k);
        return H2W'((k / KEY_W'(T1_DEPTH)) % KEY_W'(T2_DEPTH));
    endfunction

    // Table and value RAMs: contents are never reset, the valid bits qualify them.
    ent_t             t1_mem  [T1_DEPTH];
    ent_t             t2_mem  [T2_DEPTH];
    logic [VAL_W-1:0] val_mem [VAL_DEPTH];
    ent_t             t1_rd, t2_rd;
    logic [VAL_W-1:0] val_rd;

    logic             t1_re, t1_we, t2_re, t2_we, val_re, val_we;
    logic [H1W-1:0]   t1_raddr, t1_waddr;
    logic [H2W-1:0]   t2_raddr, t2_waddr;
    ent_t             t1_wdata, t2_wdata;
    logic [AW-1:0]    val_raddr, val_waddr;
    logic [VAL_W-1:0] val_wdata;

    state_t           state;
    logic [1:0]       op_r;
    logic [KEY_W-1:0] key_r;
    logic [VAL_W-1:0] data_r, bal_r;
    logic [T1_DEPTH-1:0] t1_vld;
    logic [T2_DEPTH-1:0] t2_vld;
    logic [H1W-1:0]   t1_idx;
    logic [H2W-1:0]   t2_idx;
    ent_t             cur, stash;
    logic             stash_valid;
    logic [KW-1:0]    kick;
    logic [CW-1:0]    next_free;
    logic [AW-1:0]    hit_r;
    logic [2:0]       st_r;
    logic             req_ready_r, resp_valid_r;
    logic [2:0]       resp_status_r;
    logic [VAL_W-1:0] resp_value_r;
    logic [AW-1:0]    resp_addr_r;

    logic             t1_hit, t2_hit, s_hit, any_hit, ins_ok;
    logic [AW-1:0]    hit_addr;
    logic [VAL_W:0]   sum;

    assign t1_hit   = t1_vld[t1_idx] && (t1_rd.key == key_r);
    assign t2_hit   = t2_vld[t2_idx] && (t2_rd.key == key_r);
    assign s_hit    = stash_valid && (stash.key == key_r);
    assign any_hit  = t1_hit || t2_hit || s_hit;
    assign hit_addr = t1_hit ? t1_rd.addr : (t2_hit ? t2_rd.addr : stash.addr);
    assign ins_ok   = !any_hit && (next_free != CW'(VAL_DEPTH)) && !stash_valid;
    assign sum      = {1'b0, val_rd} + {1'b0, data_r};

    always_ff @(posedge clock) begin
        if (t1_we)  t1_mem[t1_waddr]   <= t1_wdata;
        if (t2_we)  t2_mem[t2_waddr]   <= t2_wdata;
        if (val_we) val_mem[val_waddr] <= val_wdata;
        if (t1_re)  t1_rd  <= t1_mem[t1_raddr];
        if (t2_re)  t2_rd  <= t2_mem[t2_raddr];
        if (val_re) val_rd <= val_mem[val_raddr];
    end

    // Memory port decode; each read lands one cycle before the state that consumes it.
    always_comb begin
        t1_re = 1'b0; t1_raddr = '0; t1_we = 1'b0; t1_waddr = '0; t1_wdata = '0;
        t2_re = 1'b0; t2_raddr = '0; t2_we = 1'b0; t2_waddr = '0; t2_wdata = '0;
        val_re = 1'b0; val_raddr = '0; val_we = 1'b0; val_waddr = '0; val_wdata = '0;
        case (state)
            LOOKUP: begin
                t1_re = 1'b1; t1_raddr = h1(key_r);
                t2_re = 1'b1; t2_raddr = h2(key_r);
            end
            MATCH: begin
                if (op_r == OP_INSERT) begin
                    if (ins_ok) begin
                        val_we = 1'b1; val_waddr = next_free[AW-1:0]; val_wdata = data_r;
                        t1_re = 1'b1; t1_raddr = h1(key_r);
                    end
                end else if (any_hit) begin
                    val_re = 1'b1; val_raddr = hit_addr;
                end
            end
            VWRITE: begin
                val_we = 1'b1; val_waddr = hit_r; val_wdata = bal_r;
            end
            PLACE1: begin
                t1_we = 1'b1; t1_waddr = t1_idx; t1_wdata = cur;
                if (t1_vld[t1_idx]) begin
                    t2_re = 1'b1; t2_raddr = h2(t1_rd.key);
                end
            end
            PLACE2: begin
                t2_we = 1'b1; t2_waddr = t2_idx; t2_wdata = cur;
                if (t2_vld[t2_idx]) begin
                    t1_re = 1'b1; t1_raddr = h1(t2_rd.key);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            op_r          <= '0;
            key_r         <= '0;
            data_r        <= '0;
            bal_r         <= '0;
            t1_vld        <= '0;
            t2_vld        <= '0;
            t1_idx        <= '0;
            t2_idx        <= '0;
            cur           <= '0;
            stash         <= '0;
            stash_valid   <= 1'b0;
            kick          <= '0;
            next_free     <= '0;
            hit_r         <= '0;
            st_r          <= ST_OK;
            req_ready_r   <= 1'b1;
            resp_valid_r  <= 1'b0;
            resp_status_r <= '0;
            resp_value_r  <= '0;
            resp_addr_r   <= '0;
        end else begin
            resp_valid_r <= 1'b0;
            case (state)
                IDLE: if (kv.req_valid) begin
                    op_r        <= kv.req_op;
                    key_r       <= kv.req_key;
                    data_r      <= kv.req_data;
                    req_ready_r <= 1'b0;
                    state       <= LOOKUP;
                end
                LOOKUP: begin
                    t1_idx <= h1(key_r);
                    t2_idx <= h2(key_r);
                    state  <= MATCH;
                end
                MATCH: begin
                    if (op_r == OP_INSERT) begin
                        if (any_hit) begin
                            st_r <= ST_DUPLICATE; state <= RESP;
                        end else if (!ins_ok) begin
                            st_r <= ST_FULL; state <= RESP;
                        end else begin
                            cur       <= '{key: key_r, addr: next_free[AW-1:0]};
                            hit_r     <= next_free[AW-1:0];
                            bal_r     <= data_r;
                            next_free <= next_free + 1'b1;
                            kick      <= '0;
                            t1_idx    <= h1(key_r);
                            state     <= PLACE1;
                        end
                    end else if (!any_hit) begin
                        st_r <= ST_NOT_FOUND; state <= RESP;
                    end else begin
                        hit_r <= hit_addr; state <= VREAD;
                    end
                end
                VREAD: begin
                    case (op_r)
                        OP_CREDIT:
                            if (sum[VAL_W]) begin
                                st_r <= ST_OVERFLOW; state <= RESP;
                            end else begin
                                bal_r <= sum[VAL_W-1:0]; state <= VWRITE;
                            end
                        OP_DEBIT:
                            if (data_r > val_rd) begin
                                st_r <= ST_UNDERFLOW; state <= RESP;
                            end else begin
                                bal_r <= val_rd - data_r; state <= VWRITE;
                            end
                        default: begin
                            bal_r <= val_rd; st_r <= ST_OK; state <= RESP;
                        end
                    endcase
                end
                VWRITE: begin
                    st_r <= ST_OK; state <= RESP;
                end
                PLACE1: begin
                    st_r <= ST_OK;
                    if (!t1_vld[t1_idx]) begin
                        t1_vld[t1_idx] <= 1'b1; state <= RESP;
                    end else if (kick == KW'(MAX_KICKS - 1)) begin
                        stash <= t1_rd; stash_valid <= 1'b1; state <= RESP;
                    end else begin
                        cur <= t1_rd; kick <= kick + 1'b1;
                        t2_idx <= h2(t1_rd.key); state <= PLACE2;
                    end
                end
                PLACE2: begin
                    st_r <= ST_OK;
                    if (!t2_vld[t2_idx]) begin
                        t2_vld[t2_idx] <= 1'b1; state <= RESP;
                    end else if (kick == KW'(MAX_KICKS - 1)) begin
                        stash <= t2_rd; stash_valid <= 1'b1; state <= RESP;
                    end else begin
                        cur <= t2_rd; kick <= kick + 1'b1;
                        t1_idx <= h1(t2_rd.key); state <= PLACE1;
                    end
                end
                RESP: begin
                    resp_valid_r  <= 1'b1;
                    resp_status_r <= st_r;
                    resp_value_r  <= (st_r == ST_OK) ? bal_r : '0;
                    resp_addr_r   <= (st_r == ST_OK) ? hit_r : '0;
                    req_ready_r   <= 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign kv.req_ready   = req_ready_r;
    assign kv.resp_valid  = resp_valid_r;
    assign kv.resp_status = resp_status_r;
    assign kv.resp_value  = resp_value_r;
    assign kv.resp_addr   = resp_addr_r;
    assign kv.entry_count = next_free;
endmodule
